// File: rtl/seg7_pkg.sv
// Shared types, glyph table and helpers for the seven-segment value display.
package seg7_pkg;

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  localparam logic [6:0] DASH  = 7'h40;
  localparam logic [6:0] BLANK = 7'h00;

  // Active-high glyphs, bit0 = segment a; index 15 listed first.
  localparam logic [15:0][6:0] GLYPHS = '{
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};

  function automatic logic [6:0] glyph(input logic [3:0] nibble);
    return GLYPHS[nibble];
  endfunction

  function automatic logic [63:0] pow_u(input int base, input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'(base);
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift/add-3 step per cycle, IN_W steps per conversion.
module bin2bcd_seq #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(IN_W+1);

  logic [IN_W-1:0] sh_q;
  logic [BW-1:0]   bcd_q, adj;
  logic [CW-1:0]   cnt_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  // Bits shifted past the top digit are dropped; the caller flags overflow itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q  <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else if (start) begin
      sh_q  <= bin;
      bcd_q <= '0;
      cnt_q <= CW'(IN_W);
    end else if (cnt_q != '0) begin
      bcd_q <= {adj[BW-2:0], sh_q[IN_W-1]};
      sh_q  <= sh_q << 1;
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // High during the final step; bcd holds the result after that edge.
  assign done = (cnt_q == CW'(1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_value_display.sv
// Latches a value and renders it in hex or decimal on DIGITS seven-segment digits.
module seg7_value_display
  import seg7_pkg::*;
#(
  parameter int IN_W       = 8,
  parameter int DIGITS     = 3,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       value_i,
  input  logic                  load_i,
  input  logic                  mode_i,
  input  logic                  blank_lz_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ovf_o,
  output logic [7*DIGITS-1:0]   seg_o,
  output logic [IN_W-1:0]       led_o
);
  localparam int BW  = 4*DIGITS;
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [63:0] DEC_LIM = pow_u(10, DIGITS);

  state_t state_q, state_d;
  logic [IN_W-1:0] val_q;
  logic mode_q, blank_q, ovf_q, done_q, disp_ovf_q, phase_q;
  logic [DIGITS-1:0][6:0] pat_q, pat_d;
  logic [BCW-1:0] bcnt_q;
  logic [BW-1:0] bcd, hex_ext, nib;
  logic conv_done, accept, ovf_now, seen;

  assign accept  = (state_q == IDLE) && load_i;
  assign ovf_now = mode_i ? (64'(value_i) >= DEC_LIM) : (|(value_i >> BW));
  assign hex_ext = BW'(val_q);

  bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) u_b2b (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && mode_i),
    .bin   (value_i),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_i) state_d = mode_i ? CONV : UPDATE;
      CONV:    if (conv_done) state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Walk from the top digit down; blank until the first non-zero digit.
  always_comb begin
    seen  = 1'b0;
    nib   = mode_q ? bcd : hex_ext;
    pat_d = '0;
    for (int i = DIGITS-1; i >= 0; i--) begin
      seen = seen | (nib[4*i +: 4] != 4'd0);
      if (ovf_q)                            pat_d[i] = DASH;
      else if (blank_q && !seen && i != 0)  pat_d[i] = BLANK;
      else                                  pat_d[i] = glyph(nib[4*i +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      val_q      <= '0;
      mode_q     <= 1'b0;
      blank_q    <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      disp_ovf_q <= 1'b0;
      pat_q      <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == UPDATE);
      if (accept) begin
        val_q   <= value_i;
        mode_q  <= mode_i;
        blank_q <= blank_lz_i;
        ovf_q   <= ovf_now;
      end
      if (state_q == UPDATE) begin
        pat_q      <= pat_d;
        disp_ovf_q <= ovf_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else if (bcnt_q == BCW'(BLINK_DIV-1)) begin
      bcnt_q  <= '0;
      phase_q <= ~phase_q;
    end else begin
      bcnt_q  <= bcnt_q + BCW'(1);
    end
  end

  // Overflow dashes go dark in the odd blink phase; polarity applied last.
  assign seg_o  = ((disp_ovf_q && phase_q) ? '0 : pat_q) ^ {(7*DIGITS){ACTIVE_LOW}};
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign ovf_o  = ovf_q;
  assign led_o  = val_q;

endmodule
